// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one physical memory port between the I-cache and D-cache
//
// Optional build macro: MEM_ARBITER_RR_EN
//   undefined : simultaneous requests in IDLE always go to the data side
//   defined   : a 1-bit round-robin pointer breaks ties (resets to favour data)
//
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   i_read, i_addr                    instruction-side line read request (held until i_resp)
//   i_rdata, i_resp                   instruction-side read data and completion pulse
//   d_read, d_write, d_addr, d_wdata  data-side line read/write request (held until d_resp)
//   d_rdata, d_resp                   data-side read data and completion pulse
//   mem_read, mem_write, mem_addr,
//   mem_wdata                         physical memory command
//   mem_rdata, mem_resp               physical memory read data and completion pulse
//   grant_d                           high while the data side owns the port
//   err_proto                         sticky protocol-error flag (cleared by reset only)

module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              grant_d,
  output logic              err_proto
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              d_req;
  logic              pick_d;
  logic              pick_i;
  logic              proto_bad;

  // Command actually presented to memory this cycle
  logic              cmd_read;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LINE_W-1:0] cmd_wdata;

  // Last command sampled from the granted side; replayed if it drops its request early
  logic              lat_read;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;

  assign d_req = d_read | d_write;

`ifdef MEM_ARBITER_RR_EN
  logic rr_fav_i;

  assign pick_d = d_req & (~i_read | ~rr_fav_i);

  // Flip only when the favoured side finishes, so the other side wins the next tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_fav_i <= 1'b0;
    end else if ((i_resp && rr_fav_i) || (d_resp && !rr_fav_i)) begin
      rr_fav_i <= ~rr_fav_i;
    end
  end
`else
  assign pick_d = d_req;
`endif

  assign pick_i = i_read & ~pick_d;

  always_comb begin
    cmd_read  = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    proto_bad = 1'b0;
    case (state)
      SERVE_I: begin
        if (i_read) begin
          cmd_read = 1'b1;
          cmd_addr = i_addr;
        end else begin
          cmd_read  = lat_read;
          cmd_addr  = lat_addr;
          proto_bad = 1'b1;
        end
      end
      SERVE_D: begin
        if (d_req) begin
          // read+write together is illegal; the write wins
          cmd_write = d_write;
          cmd_read  = d_read & ~d_write;
          cmd_addr  = d_addr;
          cmd_wdata = d_wdata;
          proto_bad = d_read & d_write;
        end else begin
          cmd_read  = lat_read;
          cmd_write = lat_write;
          cmd_addr  = lat_addr;
          cmd_wdata = lat_wdata;
          proto_bad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (pick_d)      state_nxt = SERVE_D;
        else if (pick_i) state_nxt = SERVE_I;
        else             state_nxt = IDLE;
      end
      SERVE_I: state_nxt = mem_resp ? IDLE : SERVE_I;
      SERVE_D: state_nxt = mem_resp ? IDLE : SERVE_D;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      err_proto <= 1'b0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (proto_bad) err_proto <= 1'b1;
      if (state == IDLE) begin
        // Capture the side about to be granted so an immediate drop still has a command
        if (pick_d) begin
          lat_read  <= d_read & ~d_write;
          lat_write <= d_write;
          lat_addr  <= d_addr;
          lat_wdata <= d_wdata;
        end else begin
          lat_read  <= i_read;
          lat_write <= 1'b0;
          lat_addr  <= i_addr;
          lat_wdata <= '0;
        end
      end else begin
        lat_read  <= cmd_read;
        lat_write <= cmd_write;
        lat_addr  <= cmd_addr;
        lat_wdata <= cmd_wdata;
      end
    end
  end

  assign mem_read  = cmd_read;
  assign mem_write = cmd_write;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign grant_d   = (state == SERVE_D);
  assign i_resp    = (state == SERVE_I) & mem_resp;
  assign d_resp    = (state == SERVE_D) & mem_resp;
  assign i_rdata   = (state != IDLE) ? mem_rdata : '0;
  assign d_rdata   = (state != IDLE) ? mem_rdata : '0;

endmodule
